// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the single-port memory arbiter.
// The AW/DW defaults are the CPU-wide address and data widths.
package mem_arb_pkg;

  localparam int unsigned CpuAw = 16;
  localparam int unsigned CpuDw = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGntIf = 2'd1,
    StGntMa = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnMa = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one req/ack memory port.
// Data wins ties; a starvation counter periodically hands a waiting fetch the port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = CpuAw,
  parameter int unsigned DW         = CpuDw,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  // Fetch requester
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  // Data requester
  input  logic          ma_req,
  input  logic          ma_we,
  input  logic [AW-1:0] ma_addr,
  input  logic [DW-1:0] ma_wdata,
  output logic [DW-1:0] ma_rdata,
  output logic          ma_ack,
  // Shared memory port
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy
);

  localparam int unsigned    CntW   = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  arb_state_e      state_q;
  logic [CntW-1:0] starve_cnt_q;
  logic            if_elig;
  logic            ma_elig;
  logic            any_elig;
  arb_owner_e      pick;

  // A requester being acked this cycle still shows its old req; keep it out of arbitration.
  assign if_elig  = if_req & ~if_ack;
  assign ma_elig  = ma_req & ~ma_ack;
  assign any_elig = if_elig | ma_elig;

  always_comb begin
    pick = OwnMa;
    if (if_elig && (!ma_elig || (starve_cnt_q == CntMax))) begin
      pick = OwnIf;
    end
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_ack       <= 1'b0;
      ma_ack       <= 1'b0;
      if_rdata     <= '0;
      ma_rdata     <= '0;
    end else begin
      if_ack <= 1'b0;
      ma_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_elig) begin
            mem_req <= 1'b1;
            if (pick == OwnMa) begin
              state_q   <= StGntMa;
              mem_we    <= ma_we;
              mem_addr  <= ma_addr;
              mem_wdata <= ma_wdata;
              if (!if_req) begin
                starve_cnt_q <= '0;
              end else if (starve_cnt_q != CntMax) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
              end
            end else begin
              state_q      <= StGntIf;
              mem_we       <= 1'b0;
              mem_addr     <= if_addr;
              mem_wdata    <= '0;
              starve_cnt_q <= '0;
            end
          end
        end
        StGntIf: begin
          if (mem_ack) begin
            state_q  <= StIdle;
            mem_req  <= 1'b0;
            if_ack   <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        StGntMa: begin
          if (mem_ack) begin
            state_q  <= StIdle;
            mem_req  <= 1'b0;
            ma_ack   <= 1'b1;
            ma_rdata <= mem_we ? '0 : mem_rdata;
          end
        end
        default: begin
          state_q <= StIdle;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
